// File: rtl/k6502_pkg.sv
// Shared definitions for the k6502 address unit: command and state encodings,
// plus the interrupt/reset vector indices.
package k6502_pkg;

  typedef enum logic [2:0] {
    CMD_NOP     = 3'd0,
    CMD_INC_PC  = 3'd1,
    CMD_LATCH_L = 3'd2,
    CMD_LATCH_H = 3'd3,
    CMD_JUMP    = 3'd4,
    CMD_BRANCH  = 3'd5,
    CMD_VECTOR  = 3'd6,
    CMD_INC_DL  = 3'd7
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BR_FIX = 2'd1,
    ST_VEC_LO = 2'd2,
    ST_VEC_HI = 2'd3
  } state_e;

  localparam logic [1:0] VEC_NMI   = 2'd0;
  localparam logic [1:0] VEC_RESET = 2'd1;
  localparam logic [1:0] VEC_IRQ   = 2'd2;

  // Index 3 has no vector slot; it aliases onto IRQ.
  function automatic logic [1:0] clamp_vec(input logic [1:0] sel);
    clamp_vec = (sel == 2'd3) ? VEC_IRQ : sel;
  endfunction

endpackage

// File: rtl/byte_counter.sv
// W-bit register with load, increment and decrement. carry_o flags that an
// increment would wrap (all ones); borrow_o flags that a decrement would wrap (zero).
module byte_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] q_o,
  output logic         carry_o,
  output logic         borrow_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end else if (dec_i) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o      = cnt_q;
  assign carry_o  = &cnt_q;
  assign borrow_o = ~|cnt_q;

endmodule

// File: rtl/addr_unit.sv
// k6502 program counter, data latch and address-bus generator, including
// relative branches with page-cross fix-up and vector fetches.
module addr_unit
  import k6502_pkg::*;
#(
  parameter int unsigned           DATA_W    = 8,
  parameter logic [2*DATA_W-1:0]   VEC_BASE  = 16'hFFFA,
  parameter logic [1:0]            RESET_VEC = VEC_RESET
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     d_in,
  input  logic [2:0]            cmd,
  input  logic [1:0]            vec_sel,
  input  logic                  addr_sel,
  output logic [2*DATA_W-1:0]   a,
  output logic [2*DATA_W-1:0]   pc,
  output logic                  busy,
  output logic                  done,
  output logic                  page_cross
);

  localparam int unsigned AW = 2 * DATA_W;

  state_e      state_q, state_d;
  logic [1:0]  vidx_q, vidx_d;
  logic        dir_q, dir_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pcross_q, pcross_d;

  logic [DATA_W-1:0] pc_lo, pc_hi, dl_lo, dl_hi;
  logic              pcl_carry, pcl_borrow, pch_carry, pch_borrow;
  logic              dll_carry, dll_borrow, dlh_carry, dlh_borrow;

  logic              pcl_ld, pcl_inc, pch_ld, pch_inc, pch_dec;
  logic              dll_ld, dll_inc, dlh_ld, dlh_inc;
  logic [DATA_W-1:0] pcl_val, pch_val, dll_val, dlh_val;

  logic [DATA_W:0]   br_sum;
  logic              br_neg, br_fix;
  logic              unused_flags;

  byte_counter #(.W(DATA_W)) u_pc_lo (
    .clk(clk), .rst(rst), .load_i(pcl_ld), .load_val_i(pcl_val),
    .inc_i(pcl_inc), .dec_i(1'b0), .q_o(pc_lo),
    .carry_o(pcl_carry), .borrow_o(pcl_borrow)
  );

  byte_counter #(.W(DATA_W)) u_pc_hi (
    .clk(clk), .rst(rst), .load_i(pch_ld), .load_val_i(pch_val),
    .inc_i(pch_inc), .dec_i(pch_dec), .q_o(pc_hi),
    .carry_o(pch_carry), .borrow_o(pch_borrow)
  );

  byte_counter #(.W(DATA_W)) u_dl_lo (
    .clk(clk), .rst(rst), .load_i(dll_ld), .load_val_i(dll_val),
    .inc_i(dll_inc), .dec_i(1'b0), .q_o(dl_lo),
    .carry_o(dll_carry), .borrow_o(dll_borrow)
  );

  byte_counter #(.W(DATA_W)) u_dl_hi (
    .clk(clk), .rst(rst), .load_i(dlh_ld), .load_val_i(dlh_val),
    .inc_i(dlh_inc), .dec_i(1'b0), .q_o(dl_hi),
    .carry_o(dlh_carry), .borrow_o(dlh_borrow)
  );

  // Only the low-byte carries drive the ripple into the high byte.
  assign unused_flags = ^{pcl_borrow, pch_carry, pch_borrow,
                          dll_borrow, dlh_carry, dlh_borrow};

  // A fix-up is needed when the signed offset moved the low byte across a page.
  assign br_sum = {1'b0, pc_lo} + {1'b0, d_in};
  assign br_neg = d_in[DATA_W-1];
  assign br_fix = br_neg ? ~br_sum[DATA_W] : br_sum[DATA_W];

  always_comb begin
    state_d  = state_q;
    vidx_d   = vidx_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    pcross_d = 1'b0;
    pcl_ld   = 1'b0;
    pcl_val  = '0;
    pcl_inc  = 1'b0;
    pch_ld   = 1'b0;
    pch_val  = '0;
    pch_inc  = 1'b0;
    pch_dec  = 1'b0;
    dll_ld   = 1'b0;
    dll_val  = '0;
    dll_inc  = 1'b0;
    dlh_ld   = 1'b0;
    dlh_val  = '0;
    dlh_inc  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        case (cmd)
          CMD_INC_PC: begin
            pcl_inc = 1'b1;
            pch_inc = pcl_carry;
          end
          CMD_LATCH_L: begin
            dll_ld  = 1'b1;
            dll_val = d_in;
          end
          CMD_LATCH_H: begin
            dlh_ld  = 1'b1;
            dlh_val = d_in;
          end
          CMD_JUMP: begin
            pcl_ld  = 1'b1;
            pcl_val = dl_lo;
            pch_ld  = 1'b1;
            pch_val = d_in;
          end
          CMD_BRANCH: begin
            pcl_ld  = 1'b1;
            pcl_val = br_sum[DATA_W-1:0];
            if (br_fix) begin
              dir_d   = br_neg;
              state_d = ST_BR_FIX;
            end else begin
              done_d = 1'b1;
            end
          end
          CMD_VECTOR: begin
            vidx_d  = clamp_vec(vec_sel);
            state_d = ST_VEC_LO;
          end
          CMD_INC_DL: begin
            dll_inc = 1'b1;
            dlh_inc = dll_carry;
          end
          default: ;
        endcase
      end
      ST_BR_FIX: begin
        pch_inc  = ~dir_q;
        pch_dec  = dir_q;
        pcross_d = 1'b1;
        done_d   = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_VEC_LO: begin
        dll_ld  = 1'b1;
        dll_val = d_in;
        state_d = ST_VEC_HI;
      end
      ST_VEC_HI: begin
        pcl_ld  = 1'b1;
        pcl_val = dl_lo;
        pch_ld  = 1'b1;
        pch_val = d_in;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_VEC_LO;
      vidx_q   <= RESET_VEC;
      dir_q    <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
      pcross_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      vidx_q   <= vidx_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pcross_q <= pcross_d;
    end
  end

  // During BR_FIX the bus still shows the unfixed PC, as on the original part.
  always_comb begin
    a = {pc_hi, pc_lo};
    case (state_q)
      ST_IDLE:   a = addr_sel ? {dl_hi, dl_lo} : {pc_hi, pc_lo};
      ST_BR_FIX: a = {pc_hi, pc_lo};
      ST_VEC_LO: a = VEC_BASE + AW'({vidx_q, 1'b0});
      ST_VEC_HI: a = VEC_BASE + AW'({vidx_q, 1'b1});
      default:   a = {pc_hi, pc_lo};
    endcase
  end

  assign pc         = {pc_hi, pc_lo};
  assign busy       = busy_q;
  assign done       = done_q;
  assign page_cross = pcross_q;

endmodule

// File: tb/tb_addr_unit.sv
// Directed bench for addr_unit: reset-vector fetch, a per-cycle vector table
// covering branches, wraps and vector fetches, and reset during a branch fix-up.
module tb_addr_unit;

  localparam logic [2:0] NOP = 3'd0, INC = 3'd1, LL = 3'd2, LH = 3'd3;
  localparam logic [2:0] JMP = 3'd4, BR = 3'd5, VEC = 3'd6, IDL = 3'd7;

  logic        clk, rst;
  logic [7:0]  d_in;
  logic [2:0]  cmd;
  logic [1:0]  vec_sel;
  logic        addr_sel;
  logic [15:0] a, pc;
  logic        busy, done, page_cross;

  int n_chk  = 0;
  int n_fail = 0;

  addr_unit #(.DATA_W(8), .VEC_BASE(16'hFFFA), .RESET_VEC(2'd1)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .cmd(cmd), .vec_sel(vec_sel),
    .addr_sel(addr_sel), .a(a), .pc(pc), .busy(busy), .done(done),
    .page_cross(page_cross)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  cmd;
    logic [7:0]  d;
    logic        sel;
    logic [1:0]  vs;
    logic [15:0] pc;
    logic [15:0] a;
    logic        busy;
    logic        done;
    logic        pcross;
  } row_t;

  localparam int NV = 32;
  row_t tbl [NV];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [15:0] e_pc, input logic [15:0] e_a,
                         input logic e_busy, input logic e_done, input logic e_pcross);
    chk({nm, " pc"}, pc, e_pc);
    chk({nm, " a"}, a, e_a);
    chk({nm, " busy"}, 16'(busy), 16'(e_busy));
    chk({nm, " done"}, 16'(done), 16'(e_done));
    chk({nm, " page_cross"}, 16'(page_cross), 16'(e_pcross));
  endtask

  initial begin
    // cmd, d_in, addr_sel, vec_sel -> pc, a, busy, done, page_cross after the edge
    tbl[0]  = '{LL,  8'h30, 1'b0, 2'd0, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{JMP, 8'h12, 1'b1, 2'd0, 16'h1230, 16'h0030, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{BR,  8'h05, 1'b0, 2'd0, 16'h1235, 16'h1235, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{LL,  8'hF0, 1'b1, 2'd0, 16'h1235, 16'h00F0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{JMP, 8'h12, 1'b0, 2'd0, 16'h12F0, 16'h12F0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{BR,  8'h20, 1'b0, 2'd0, 16'h1210, 16'h1210, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{INC, 8'h00, 1'b1, 2'd0, 16'h1310, 16'h00F0, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{LL,  8'h05, 1'b0, 2'd0, 16'h1310, 16'h1310, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{JMP, 8'h12, 1'b0, 2'd0, 16'h1205, 16'h1205, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{BR,  8'hF0, 1'b0, 2'd0, 16'h12F5, 16'h12F5, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{NOP, 8'h00, 1'b0, 2'd0, 16'h11F5, 16'h11F5, 1'b0, 1'b1, 1'b1};
    tbl[11] = '{BR,  8'hFE, 1'b0, 2'd0, 16'h11F3, 16'h11F3, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{LL,  8'hFF, 1'b1, 2'd0, 16'h11F3, 16'h00FF, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{JMP, 8'hFF, 1'b0, 2'd0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{INC, 8'h00, 1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{LH,  8'hFF, 1'b1, 2'd0, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{IDL, 8'h00, 1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{INC, 8'h00, 1'b0, 2'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{LL,  8'hFF, 1'b0, 2'd0, 16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
    tbl[19] = '{JMP, 8'h12, 1'b0, 2'd0, 16'h12FF, 16'h12FF, 1'b0, 1'b0, 1'b0};
    tbl[20] = '{INC, 8'h00, 1'b0, 2'd0, 16'h1300, 16'h1300, 1'b0, 1'b0, 1'b0};
    tbl[21] = '{IDL, 8'h00, 1'b1, 2'd0, 16'h1300, 16'h0100, 1'b0, 1'b0, 1'b0};
    tbl[22] = '{VEC, 8'h00, 1'b0, 2'd2, 16'h1300, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[23] = '{NOP, 8'hCD, 1'b0, 2'd0, 16'h1300, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[24] = '{INC, 8'hAB, 1'b0, 2'd0, 16'hABCD, 16'hABCD, 1'b0, 1'b1, 1'b0};
    tbl[25] = '{NOP, 8'h00, 1'b0, 2'd0, 16'hABCD, 16'hABCD, 1'b0, 1'b0, 1'b0};
    tbl[26] = '{VEC, 8'h00, 1'b0, 2'd3, 16'hABCD, 16'hFFFE, 1'b1, 1'b0, 1'b0};
    tbl[27] = '{NOP, 8'h11, 1'b0, 2'd0, 16'hABCD, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    tbl[28] = '{NOP, 8'h22, 1'b0, 2'd0, 16'h2211, 16'h2211, 1'b0, 1'b1, 1'b0};
    tbl[29] = '{VEC, 8'h00, 1'b0, 2'd0, 16'h2211, 16'hFFFA, 1'b1, 1'b0, 1'b0};
    tbl[30] = '{NOP, 8'h78, 1'b0, 2'd0, 16'h2211, 16'hFFFB, 1'b1, 1'b0, 1'b0};
    tbl[31] = '{NOP, 8'h56, 1'b0, 2'd0, 16'h5678, 16'h5678, 1'b0, 1'b1, 1'b0};

    rst = 1'b1; d_in = 8'h00; cmd = NOP; vec_sel = 2'd0; addr_sel = 1'b0;
    step();
    step();
    chk_all("reset", 16'h0000, 16'hFFFC, 1'b1, 1'b0, 1'b0);

    // Reset-vector fetch
    rst = 1'b0;
    d_in = 8'h34;
    chk("rv lo a", a, 16'hFFFC);
    step();
    chk_all("rv hi", 16'h0000, 16'hFFFD, 1'b1, 1'b0, 1'b0);
    d_in = 8'h12;
    step();
    chk_all("rv done", 16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0);
    step();
    chk_all("rv idle", 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < NV; i++) begin
      cmd      = tbl[i].cmd;
      d_in     = tbl[i].d;
      addr_sel = tbl[i].sel;
      vec_sel  = tbl[i].vs;
      step();
      chk_all($sformatf("row%0d", i), tbl[i].pc, tbl[i].a,
              tbl[i].busy, tbl[i].done, tbl[i].pcross);
    end

    // Reset asserted while a branch fix-up is pending
    cmd = LL; d_in = 8'hF0; addr_sel = 1'b0; vec_sel = 2'd0;
    step();
    cmd = JMP; d_in = 8'h12;
    step();
    cmd = BR; d_in = 8'h20;
    step();
    chk_all("brfix", 16'h1210, 16'h1210, 1'b1, 1'b0, 1'b0);
    cmd = NOP; d_in = 8'h00;
    rst = 1'b1;
    #1;
    chk_all("rst in brfix", 16'h0000, 16'hFFFC, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("rst held", 16'h0000, 16'hFFFC, 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    d_in = 8'h00;
    step();
    chk_all("rv2 hi", 16'h0000, 16'hFFFD, 1'b1, 1'b0, 1'b0);
    d_in = 8'hC0;
    step();
    chk_all("rv2 done", 16'hC000, 16'hC000, 1'b0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/addr_unit.md
# addr_unit

Parametrised program-counter and address-generation unit for the k6502 core. It replaces the split `pc`/`data_latch` pair with one block that owns the PC, the data latch (DL), the address-bus mux and the multi-cycle address sequences. Those sequences are relative branches with page-cross fix-up and the vector fetch, including the automatic reset-vector fetch. It sits between the microcode decoder, which issues `cmd`, and the external address and data buses.

## Interface
- `DATA_W`, default 8: data bus width; address width is fixed at 2*DATA_W.
- `VEC_BASE`, default 16'hFFFA: address of vector 0; vector n low byte is at VEC_BASE+2n.
- `RESET_VEC`, default 1: vector index fetched after reset.
- `clk`  in  1: clock; every register updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `d_in`  in  DATA_W: read data bus.
- `cmd`  in  3: 0 NOP, 1 INC_PC, 2 LATCH_L, 3 LATCH_H, 4 JUMP, 5 BRANCH, 6 VECTOR, 7 INC_DL.
- `vec_sel`  in  2: vector index used with VECTOR; values 0..2.
- `addr_sel`  in  1: in IDLE, 0 drives `a`=PC and 1 drives `a`=DL.
- `a`  out  2*DATA_W: address bus, combinational from state and registers.
- `pc`  out  2*DATA_W: current PC.
- `busy`  out  1: high while the FSM is not IDLE; `cmd` is ignored while high.
- `done`  out  1: one-cycle pulse when a BRANCH or VECTOR completes.
- `page_cross`  out  1: one-cycle pulse in the cycle a branch high-byte fix-up is applied.

## Operation
- FSM states: IDLE, BR_FIX, VEC_LO, VEC_HI.
- Reset values:
  - state = VEC_LO and vidx = RESET_VEC.
  - pc = 0, dl = 0.
  - busy = 1, done = 0, page_cross = 0.
- IDLE commands, each applied on the clock edge:
  - INC_PC: pc <= pc+1, wrapping from all-ones to 0.
  - LATCH_L: dl[lo] <= d_in.
  - LATCH_H: dl[hi] <= d_in.
  - INC_DL: dl <= dl+1, wrapping.
  - JUMP: pc <= {d_in, dl[lo]}.
  - BRANCH: d_in is a signed offset. Compute sum = pc[lo]+d_in as DATA_W+1 bits and set pc[lo] <= sum[DATA_W-1:0].
    - Fix-up is needed when the offset is non-negative with carry-out, or negative without carry-out.
    - No fix-up: `done` pulses the next cycle and the FSM stays in IDLE.
    - Fix-up needed: latch the direction and go to BR_FIX.
  - VECTOR: vidx <= vec_sel, then go to VEC_LO.
  - NOP: no change.
- BR_FIX: pc[hi] <= pc[hi]±1, wrapping. Assert `page_cross` and `done`, then return to IDLE.
- VEC_LO: `a` = VEC_BASE+2*vidx. On the edge, dl[lo] <= d_in and go to VEC_HI.
- VEC_HI: `a` = VEC_BASE+2*vidx+1. On the edge, pc <= {d_in, dl[lo]}, `done` pulses, and the FSM goes to IDLE.
- In BR_FIX, `a` = PC, showing the not-yet-fixed address, as the 6502 does.
- `vec_sel`=3 is treated as 2.

## Timing
- `done` and `page_cross` are registered and valid the cycle after the completing edge.
- Latencies:
  - Single-byte commands: 1 cycle.
  - BRANCH with no page cross: 1 cycle.
  - BRANCH with a page cross: 2 cycles.
  - VECTOR: 3 cycles (accept, VEC_LO, VEC_HI).
  - Reset-vector fetch: 2 cycles after `rst` deasserts.
- `cmd` is sampled only when `busy`=0; commands issued while busy are dropped, not queued.
- Asserting `rst` mid-sequence immediately aborts it, restores the reset values and restarts the reset-vector fetch.
- `d_in` must be stable at each sampling edge; there is no internal bus latch.

## Structure
- Shared package `k6502_pkg`: cmd encodings, FSM state encoding, vector index constants (NMI=0, RESET=1, IRQ=2).
- Sub-module `byte_counter` (DATA_W-wide register with load, increment and decrement, plus carry and borrow out), instantiated for pc_lo, pc_hi, dl_lo and dl_hi.
- Top-level FSM, branch adder and `a` mux live in `addr_unit`.

## Test plan
- Reset vector fetch: release `rst`; d_in=8'h34 while `a`=16'hFFFC, then 8'h12 while `a`=16'hFFFD. Expect pc=16'h1234, one `done` pulse, `busy` low at the third cycle.
- Forward branch, same page: pc=16'h1230, BRANCH with d_in=8'h05. Expect pc=16'h1235, `done` after 1 cycle, no `page_cross`.
- Forward cross: pc=16'h12F0, d_in=8'h20. Expect 16'h1210, then 16'h1310 with `page_cross` and `done`. Backward cross: pc=16'h1205, d_in=8'hF0. Expect 16'h12F5, then 16'h11F5.
- Wrap: pc=16'hFFFF with INC_PC gives 16'h0000; dl=16'hFFFF with INC_DL gives 16'h0000.
- VECTOR with vec_sel=2: `a` reads 16'hFFFE then 16'hFFFF; d_in 8'hCD then 8'hAB gives pc=16'hABCD. An INC_PC issued during VEC_HI is ignored.
- Assert `rst` during BR_FIX: pc=0, no `page_cross`, FSM in VEC_LO with `a`=16'hFFFC.
